ex_div_ctrl: RTL and testbench

//  Iterative 32-bit divide sequencer in the EX stage for DIV.W/MOD.W/DIV.WU/MOD.WU.

---
 rtl/ex_div_ctrl_pkg.sv | 29 ++
 rtl/ex_div_ctrl_div_iter_step.sv | 21 ++
 rtl/ex_div_ctrl.sv | 142 ++++++++++++++
 tb/tb_ex_div_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the EX-stage divider.
package ex_div_ctrl_pkg;

  localparam logic [7:0] OP_DIV_W  = 8'h20;
  localparam logic [7:0] OP_MOD_W  = 8'h21;
  localparam logic [7:0] OP_DIV_WU = 8'h22;
  localparam logic [7:0] OP_MOD_WU = 8'h23;

  typedef enum logic [2:0] {
    DIV_ST_IDLE = 3'd0,
    DIV_ST_PREP = 3'd1,
    DIV_ST_CALC = 3'd2,
    DIV_ST_FIX  = 3'd3,
    DIV_ST_DONE = 3'd4
  } div_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV_W) || (op == OP_MOD_W) || (op == OP_DIV_WU) || (op == OP_MOD_WU);
  endfunction

  function automatic logic op_is_signed(input logic [7:0] op);
    return (op == OP_DIV_W) || (op == OP_MOD_W);
  endfunction

  function automatic logic op_is_mod(input logic [7:0] op);
    return (op == OP_MOD_W) || (op == OP_MOD_WU);
  endfunction

endpackage

// File: rtl/ex_div_ctrl_div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quot} left, subtract divisor when it fits.
module div_iter_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quot_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quot_out
);

  logic [DATA_W:0] w_trial;
  logic            w_ge;

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_trial  = {rem_in, quot_in[DATA_W-1]};
  assign w_ge     = (w_trial >= {1'b0, divisor});
  assign rem_out  = w_ge ? (w_trial[DATA_W-1:0] - divisor) : w_trial[DATA_W-1:0];
  assign quot_out = {quot_in[DATA_W-2:0], w_ge};

endmodule

// File: rtl/ex_div_ctrl.sv
// Iterative 32-bit divide sequencer for DIV.W/MOD.W/DIV.WU/MOD.WU; stalls EX while busy.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         CNT_W     = 6,
  parameter logic [DATA_W-1:0]   DIV0_QUOT = '1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_req,
  input  logic [7:0]        div_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  input  logic              res_ready,
  output logic              ex_stall,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result
);

  div_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_dvsr;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quot;
  logic              r_signed;
  logic              r_mod;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_div0;
  logic              r_done;
  logic [DATA_W-1:0] r_result;

  logic              w_is_div;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quot_nxt;
  logic [DATA_W-1:0] w_quot_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_is_div = div_req & is_div_op(div_op);

  assign w_abs_a = (r_signed & r_a[DATA_W-1]) ? (-r_a) : r_a;
  assign w_abs_b = (r_signed & r_b[DATA_W-1]) ? (-r_b) : r_b;

  // Divide-by-zero results are returned raw, never sign-corrected.
  assign w_quot_fix = (!r_div0 && r_sign_q) ? (-r_quot) : r_quot;
  assign w_rem_fix  = (!r_div0 && r_sign_r) ? (-r_rem)  : r_rem;

  div_iter_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in   (r_rem),
    .quot_in  (r_quot),
    .divisor  (r_dvsr),
    .rem_out  (w_rem_nxt),
    .quot_out (w_quot_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= DIV_ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_signed <= 1'b0;
      r_mod    <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= DIV_ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        DIV_ST_IDLE: begin
          if (w_is_div) begin
            r_a      <= src1;
            r_b      <= src2;
            r_signed <= op_is_signed(div_op);
            r_mod    <= op_is_mod(div_op);
            r_state  <= DIV_ST_PREP;
          end
        end
        DIV_ST_PREP: begin
          r_sign_q <= r_signed & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
          r_sign_r <= r_signed & r_a[DATA_W-1];
          if (r_b == '0) begin
            r_div0  <= 1'b1;
            r_quot  <= DIV0_QUOT;
            r_rem   <= r_a;
            r_state <= DIV_ST_FIX;
          end else begin
            r_div0  <= 1'b0;
            r_quot  <= w_abs_a;
            r_rem   <= '0;
            r_dvsr  <= w_abs_b;
            r_cnt   <= CNT_W'(DATA_W);
            r_state <= DIV_ST_CALC;
          end
        end
        DIV_ST_CALC: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DIV_ST_FIX;
          end
        end
        DIV_ST_FIX: begin
          r_result <= r_mod ? w_rem_fix : w_quot_fix;
          r_done   <= 1'b1;
          r_state  <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          if (res_ready) begin
            r_done  <= 1'b0;
            r_state <= DIV_ST_IDLE;
          end
        end
        default: begin
          r_state <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign ex_stall   = (w_is_div && (r_state != DIV_ST_DONE)) ||
                      ((r_state == DIV_ST_DONE) && !res_ready);
  assign div_done   = r_done;
  assign div_result = r_result;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: signed/unsigned results, latency, divide-by-zero, flush, hold and reset.
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        div_req;
  logic [7:0]  div_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        res_ready;
  logic        ex_stall;
  logic        div_done;
  logic [31:0] div_result;

  int unsigned n_pass;
  int unsigned n_total;

  ex_div_ctrl #(
    .DATA_W    (32),
    .CNT_W     (6),
    .DIV0_QUOT (32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_req    (div_req),
    .div_op     (div_op),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .res_ready  (res_ready),
    .ex_stall   (ex_stall),
    .div_done   (div_done),
    .div_result (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Cycle 0 is the cycle in which the request is first presented in IDLE.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int unsigned lat, input int unsigned hold);
    int unsigned cyc;
    logic        stall_ok;
    logic        hold_ok;
    @(negedge clk);
    res_ready = (hold == 0);
    div_req   = 1'b1;
    div_op    = op;
    src1      = a;
    src2      = b;
    #1;
    stall_ok = (ex_stall === 1'b1);
    cyc      = 0;
    while (div_done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      src1 = $urandom;
      src2 = $urandom;
      #1;
      if (div_done !== 1'b1 && ex_stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, div_result, exp);
    check({tag, " stall while busy"}, {31'd0, stall_ok}, 32'd1);
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        if (div_done !== 1'b1 || div_result !== exp || ex_stall !== 1'b1) hold_ok = 1'b0;
      end
      check({tag, " held in DONE"}, {31'd0, hold_ok}, 32'd1);
      res_ready = 1'b1;
      #1;
    end
    check({tag, " stall at hand-off"}, {31'd0, ex_stall}, 32'd0);
    @(posedge clk);
    #1;
    div_req = 1'b0;
    @(negedge clk);
    check({tag, " done cleared"}, {31'd0, div_done}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    n_pass    = 0;
    n_total   = 0;
    resetn    = 1'b0;
    div_req   = 1'b0;
    div_op    = 8'h00;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    res_ready = 1'b1;
    #12;
    check("reset done", {31'd0, div_done}, 32'd0);
    check("reset result", div_result, 32'd0);
    check("reset stall", {31'd0, ex_stall}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("DIV_W 100/7",      OP_DIV_W,  32'd100,       32'd7,         32'd14,        35, 0);
    run_op("MOD_W -7/2",       OP_MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 0);
    run_op("DIV_W -7/2",       OP_DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 0);
    run_op("DIV_W 7/-2",       OP_DIV_W,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 0);
    run_op("MOD_W 7/-2",       OP_MOD_W,  32'd7,         32'hFFFF_FFFE, 32'd1,         35, 0);
    run_op("DIV_WU max/2",     OP_DIV_WU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 35, 0);
    run_op("MOD_WU max/2",     OP_MOD_WU, 32'hFFFF_FFFF, 32'd2,         32'd1,         35, 0);
    run_op("DIV_W min/-1",     OP_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 0);
    run_op("MOD_W min/-1",     OP_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35, 0);
    run_op("DIV_W 5/0",        OP_DIV_W,  32'd5,         32'd0,         32'hFFFF_FFFF, 3,  0);
    run_op("MOD_W 5/0",        OP_MOD_W,  32'd5,         32'd0,         32'd5,         3,  0);
    run_op("MOD_W -5/0",       OP_MOD_W,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 3,  0);
    run_op("DIV_W -5/0",       OP_DIV_W,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 3,  0);
    run_op("DIV_WU 1000/10 hold", OP_DIV_WU, 32'd1000,   32'd10,        32'd100,       35, 5);

    // Flush at cycle 10 of DIV_W 100/7.
    @(negedge clk);
    div_req = 1'b1;
    div_op  = OP_DIV_W;
    src1    = 32'd100;
    src2    = 32'd7;
    for (int unsigned c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    div_req = 1'b0;
    @(negedge clk);
    check("flush stall cycle 11", {31'd0, ex_stall}, 32'd0);
    check("flush done cycle 11", {31'd0, div_done}, 32'd0);
    saw_done = 1'b0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done === 1'b1) saw_done = 1'b1;
    end
    check("flush no done", {31'd0, saw_done}, 32'd0);
    run_op("MOD_WU 9/4 after flush", OP_MOD_WU, 32'd9, 32'd4, 32'd1, 35, 0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    div_req = 1'b1;
    div_op  = OP_DIV_W;
    src1    = 32'd100;
    src2    = 32'd7;
    for (int unsigned c = 1; c <= 15; c++) @(negedge clk);
    resetn  = 1'b0;
    div_req = 1'b0;
    #1;
    check("reset mid-CALC done", {31'd0, div_done}, 32'd0);
    check("reset mid-CALC result", div_result, 32'd0);
    check("reset mid-CALC stall", {31'd0, ex_stall}, 32'd0);
    @(negedge clk);
    resetn   = 1'b1;
    saw_done = 1'b0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done === 1'b1) saw_done = 1'b1;
    end
    check("reset no done", {31'd0, saw_done}, 32'd0);
    run_op("DIV_WU 77/7 after reset", OP_DIV_WU, 32'd77, 32'd7, 32'd11, 35, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
